// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage and register file.
//   DATA_W     - register / result data width
//   REG_AW     - register address width
//   NUM_REGS   - architectural register count (2**REG_AW)
//   wb_entry_t - one buffered register write {rd, data}
package wb_pkg;

    localparam int DATA_W   = 16;
    localparam int REG_AW   = 3;
    localparam int NUM_REGS = 1 << REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order writeback buffer: up to two writes per cycle, one retire per cycle.
// The head retires on every edge where the buffer is non-empty; the caller
// must not push more than the free space allows.
// Ports:
//   clk, rst_n    - clock, async active-low reset
//   push0, push1  - enqueue din0 / din1 (din0 lands first)
//   din0, din1    - entries to enqueue
//   count         - occupied entries, 0..DEPTH
//   head_valid    - head entry is valid and retires at the next edge
//   head          - oldest entry
//   entries       - raw storage, indexed by slot
//   entry_valid   - per-slot valid mask
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push0,
    input  logic                      push1,
    input  wb_entry_t                 din0,
    input  wb_entry_t                 din1,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      head_valid,
    output wb_entry_t                 head,
    output wb_entry_t [DEPTH-1:0]     entries,
    output logic [DEPTH-1:0]          entry_valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t [DEPTH-1:0] mem;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  pop;

    assign pop        = (count != '0);
    assign head_valid = pop;
    assign head       = mem[rd_ptr];
    assign entries    = mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push0)
                mem[wr_ptr] <= din0;
            // Lane 1 takes the slot after lane 0 when both push.
            if (push1)
                mem[push0 ? wr_ptr + PTR_W'(1) : wr_ptr] <= din1;
            wr_ptr <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
        end
    end

    // A slot is live when its distance from the head is below count.
    always_comb begin
        logic [PTR_W-1:0] offset;
        offset      = '0;
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset         = PTR_W'(i) - rd_ptr;
            entry_valid[i] = ({1'b0, offset} < count);
        end
    end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage and 8-entry architectural register file.
// Two result lanes feed an in-order buffer; one entry retires per cycle into
// the register file. Read ports bypass the retiring head entry.
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   wb{0,1}_valid/rd/data      - result lanes, lane 0 older
//   wb_ready                   - both lanes may be accepted this cycle
//   rd_addr_{a,b}, rd_data_{a,b} - combinational read ports
//   busy                       - per-register pending-write flags
//   commit_valid/rd/data       - registered record of the last retire
module writeback_regfile
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wb0_valid,
    input  logic [REG_AW-1:0]   wb0_rd,
    input  logic [DATA_W-1:0]   wb0_data,
    input  logic                wb1_valid,
    input  logic [REG_AW-1:0]   wb1_rd,
    input  logic [DATA_W-1:0]   wb1_data,
    output logic                wb_ready,
    input  logic [REG_AW-1:0]   rd_addr_a,
    input  logic [REG_AW-1:0]   rd_addr_b,
    output logic [DATA_W-1:0]   rd_data_a,
    output logic [DATA_W-1:0]   rd_data_b,
    output logic [NUM_REGS-1:0] busy,
    output logic                commit_valid,
    output logic [REG_AW-1:0]   commit_rd,
    output logic [DATA_W-1:0]   commit_data
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                       accept0;
    logic                       accept1;
    logic [CNT_W-1:0]           count;
    logic                       head_valid;
    wb_entry_t                  head;
    wb_entry_t [FIFO_DEPTH-1:0] entries;
    logic [FIFO_DEPTH-1:0]      entry_valid;
    logic [DATA_W-1:0]          regs [NUM_REGS];

    // Two free slots guarantee room for a dual accept regardless of retire.
    assign wb_ready = (count <= CNT_W'(FIFO_DEPTH - 2));
    assign accept0  = wb0_valid && wb_ready && (wb0_rd != '0);
    assign accept1  = wb1_valid && wb_ready && (wb1_rd != '0);

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push0       (accept0),
        .push1       (accept1),
        .din0        ('{rd: wb0_rd, data: wb0_data}),
        .din1        ('{rd: wb1_rd, data: wb1_data}),
        .count       (count),
        .head_valid  (head_valid),
        .head        (head),
        .entries     (entries),
        .entry_valid (entry_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
            commit_valid <= 1'b0;
            commit_rd    <= '0;
            commit_data  <= '0;
        end else begin
            commit_valid <= head_valid;
            if (head_valid) begin
                regs[head.rd] <= head.data;
                commit_rd     <= head.rd;
                commit_data   <= head.data;
            end
        end
    end

    // Only the head is forwarded; younger entries are covered by busy.
    assign rd_data_a = (rd_addr_a == '0)                       ? '0        :
                       (head_valid && head.rd == rd_addr_a)    ? head.data :
                                                                 regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0)                       ? '0        :
                       (head_valid && head.rd == rd_addr_b)    ? head.data :
                                                                 regs[rd_addr_b];

    always_comb begin
        busy = '0;
        for (int i = 0; i < FIFO_DEPTH; i++)
            if (entry_valid[i])
                busy[entries[i].rd] = 1'b1;
        busy[0] = 1'b0;
    end

endmodule

// File: tb/tb_writeback_regfile.sv
module tb_writeback_regfile;
    import wb_pkg::*;

    logic                clk;
    logic                rst_n;
    logic                wb0_valid, wb1_valid;
    logic [REG_AW-1:0]   wb0_rd, wb1_rd;
    logic [DATA_W-1:0]   wb0_data, wb1_data;
    logic                wb_ready;
    logic [REG_AW-1:0]   rd_addr_a, rd_addr_b;
    logic [DATA_W-1:0]   rd_data_a, rd_data_b;
    logic [NUM_REGS-1:0] busy;
    logic                commit_valid;
    logic [REG_AW-1:0]   commit_rd;
    logic [DATA_W-1:0]   commit_data;

    int n_tests = 0;
    int n_fail  = 0;

    writeback_regfile #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb0_valid    (wb0_valid),
        .wb0_rd       (wb0_rd),
        .wb0_data     (wb0_data),
        .wb1_valid    (wb1_valid),
        .wb1_rd       (wb1_rd),
        .wb1_data     (wb1_data),
        .wb_ready     (wb_ready),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .rd_data_a    (rd_data_a),
        .rd_data_b    (rd_data_b),
        .busy         (busy),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_data  (commit_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lanes(input logic v0, input logic [REG_AW-1:0] r0, input logic [DATA_W-1:0] d0,
                         input logic v1, input logic [REG_AW-1:0] r1, input logic [DATA_W-1:0] d1);
        wb0_valid = v0; wb0_rd = r0; wb0_data = d0;
        wb1_valid = v1; wb1_rd = r1; wb1_data = d1;
    endtask

    wb_entry_t q[$];
    wb_entry_t exp_e;

    initial begin
        int     cnt_m;
        int     pairs;
        logic   drive, acc, exp_cv, saw_low;
        logic [REG_AW-1:0] r0v, r1v;
        logic [DATA_W-1:0] d0v, d1v;

        rst_n = 1'b0;
        lanes(0, 0, 0, 0, 0, 0);
        rd_addr_a = 3'd5;
        rd_addr_b = 3'd0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", wb_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd_a", rd_data_a, 0);
        chk("rst_cvalid", commit_valid, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Single write
        lanes(1, 3'd5, 16'hABCD, 0, 0, 0);
        tick();
        lanes(0, 0, 0, 0, 0, 0);
        #1;
        chk("single_bypass", rd_data_a, 16'hABCD);
        chk("single_busy", busy, 8'h20);
        chk("single_cv0", commit_valid, 0);
        tick();
        chk("single_cvalid", commit_valid, 1);
        chk("single_crd", commit_rd, 5);
        chk("single_cdata", commit_data, 16'hABCD);
        chk("single_busy_clr", busy, 0);
        chk("single_reg", rd_data_a, 16'hABCD);
        tick();
        chk("single_cv_end", commit_valid, 0);

        // Same-register pair
        rd_addr_b = 3'd2;
        lanes(1, 3'd2, 16'h1111, 1, 3'd2, 16'h2222);
        tick();
        lanes(0, 0, 0, 0, 0, 0);
        #1;
        chk("pair_busy", busy, 8'h04);
        chk("pair_bypass1", rd_data_b, 16'h1111);
        tick();
        chk("pair_c1", commit_data, 16'h1111);
        chk("pair_busy2", busy, 8'h04);
        chk("pair_bypass2", rd_data_b, 16'h2222);
        tick();
        chk("pair_c2", commit_data, 16'h2222);
        chk("pair_cv2", commit_valid, 1);
        chk("pair_busy_clr", busy, 0);
        chk("pair_final", rd_data_b, 16'h2222);

        // r0 write alongside a real write
        rd_addr_a = 3'd0;
        rd_addr_b = 3'd3;
        lanes(1, 3'd3, 16'h0042, 1, 3'd0, 16'hFFFF);
        tick();
        lanes(0, 0, 0, 0, 0, 0);
        #1;
        chk("r0_busy", busy, 8'h08);
        chk("r0_read", rd_data_a, 0);
        chk("r0_bypass", rd_data_b, 16'h0042);
        tick();
        chk("r0_crd", commit_rd, 3);
        chk("r0_cdata", commit_data, 16'h0042);
        chk("r0_read2", rd_data_a, 0);
        tick();
        chk("r0_single_entry", commit_valid, 0);
        chk("r0_busy_end", busy, 0);

        // Backpressure: both lanes valid every cycle
        cnt_m   = 0;
        pairs   = 0;
        saw_low = 0;
        for (int cyc = 0; cyc < 60 && (pairs < 6 || q.size() != 0); cyc++) begin
            drive = (pairs < 6);
            r0v = REG_AW'(pairs % 7 + 1);
            r1v = REG_AW'((pairs + 3) % 7 + 1);
            d0v = DATA_W'(16'hA000 + pairs);
            d1v = DATA_W'(16'hB000 + pairs);
            lanes(drive, r0v, d0v, drive, r1v, d1v);
            #1;
            chk("bp_ready", wb_ready, (cnt_m <= 2));
            if (!wb_ready) saw_low = 1;
            acc    = drive && (cnt_m <= 2);
            exp_cv = (cnt_m != 0);
            if (exp_cv) exp_e = q.pop_front();
            if (acc) begin
                q.push_back('{rd: r0v, data: d0v});
                q.push_back('{rd: r1v, data: d1v});
            end
            cnt_m = cnt_m + (acc ? 2 : 0) - (exp_cv ? 1 : 0);
            tick();
            chk("bp_cvalid", commit_valid, exp_cv);
            if (exp_cv) begin
                chk("bp_crd", commit_rd, exp_e.rd);
                chk("bp_cdata", commit_data, exp_e.data);
            end
            if (acc) pairs++;
        end
        lanes(0, 0, 0, 0, 0, 0);
        chk("bp_all_issued", pairs, 6);
        chk("bp_drained", q.size(), 0);
        chk("bp_ready_fell", saw_low, 1);
        chk("bp_busy_end", busy, 0);

        // Async reset with three entries buffered
        rd_addr_a = 3'd5;
        lanes(1, 3'd4, 16'h4444, 1, 3'd6, 16'h6666);
        tick();
        lanes(1, 3'd1, 16'h1010, 1, 3'd7, 16'h7070);
        tick();
        lanes(0, 0, 0, 0, 0, 0);
        #1;
        chk("ar_busy_pre", busy, 8'hC2);
        chk("ar_ready_pre", wb_ready, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_ready", wb_ready, 1);
        chk("ar_cvalid", commit_valid, 0);
        chk("ar_crd", commit_rd, 0);
        chk("ar_cdata", commit_data, 0);
        chk("ar_regs", rd_data_a, 0);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ar_no_commit", commit_valid, 0);
        end
        chk("ar_busy_end", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
